// File: rtl/fx_nth_root_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fx_nth_root_pkg
// Purpose  : Shared definitions for the fixed-point k-th root block:
//            default parameter values, result-width derivation and the
//            controller state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fx_nth_root_pkg;

    localparam int DEF_IN_INT_W = 10;
    localparam int DEF_FRAC_W   = 10;
    localparam int DEF_EXP_W    = 3;

    // Result / internal word width: integer bits of the radicand plus the
    // fractional bits carried by every fixed-point value.
    function automatic int calc_w(input int in_int_w, input int frac_w);
        return in_int_w + frac_w;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_MUL    = 3'd2,
        S_DECIDE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fx_nth_root_mul.sv
`default_nettype none
// ============================================================================
// Module   : fx_mul_trunc
// Purpose  : Truncating fixed-point multiply (p*c) >> FRAC_W with a compare
//            of the untruncated-width shifted product against the radicand.
// Ports    : p        - running power, W bits
//            c        - candidate root, W bits
//            xq       - radicand aligned to the fixed-point grid, W bits
//            product  - low W bits of (p*c) >> FRAC_W
//            exceeds  - full shifted product is larger than xq
// Revision : 1.0 - initial release
// ============================================================================
module fx_mul_trunc #(
    parameter int W      = 20,
    parameter int FRAC_W = 10
) (
    input  logic [W-1:0] p,
    input  logic [W-1:0] c,
    input  logic [W-1:0] xq,
    output logic [W-1:0] product,
    output logic         exceeds
);

    logic [2*W-1:0] w_full;
    logic [2*W-1:0] w_shift;

    // Full 2W-bit product so the overflow compare never sees a wrapped value.
    assign w_full  = {{W{1'b0}}, p} * {{W{1'b0}}, c};
    assign w_shift = w_full >> FRAC_W;

    // Only the low W bits are ever kept: whenever they are stored the
    // shifted product is <= xq and therefore fits in W bits.
    assign product = w_shift[W-1:0];
    assign exceeds = (w_shift > {{W{1'b0}}, xq});

endmodule
`default_nettype wire

// File: rtl/fx_nth_root.sv
`default_nettype none
// ============================================================================
// Module   : fx_nth_root
// Purpose  : Bit-serial fixed-point k-th root of an unsigned integer.
//            Each result bit is tried MSB first; the candidate is raised to
//            the k-th power one truncating multiply per cycle and kept if
//            no partial power exceeds the radicand.
// Ports    : clk, rst_n            - clock, async active-low reset
//            in_valid / in_ready   - request handshake
//            in_data_1             - radicand X (IN_INT_W bits, integer)
//            in_data_2             - root order k (EXP_W bits)
//            out_valid / out_ready - result handshake
//            out_data              - Q(IN_INT_W).(FRAC_W) result
//            out_err               - k == 0
// Revision : 1.0 - initial release
// ============================================================================
module fx_nth_root
    import fx_nth_root_pkg::*;
#(
    parameter int IN_INT_W = DEF_IN_INT_W,
    parameter int FRAC_W   = DEF_FRAC_W,
    parameter int EXP_W    = DEF_EXP_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_INT_W-1:0]          in_data_1,
    input  logic [EXP_W-1:0]             in_data_2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IN_INT_W+FRAC_W-1:0]   out_data,
    output logic                         out_err
);

    localparam int c_w  = calc_w(IN_INT_W, FRAC_W);
    localparam int c_bw = $clog2(c_w);

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [c_w-1:0]     r_out_data;
    logic               r_out_err;
    logic [c_w-1:0]     r_xq;
    logic [EXP_W-1:0]   r_k;
    logic [c_w-1:0]     r_r;
    logic [c_w-1:0]     r_p;
    logic [EXP_W-1:0]   r_count;
    logic [c_bw-1:0]    r_bit;
    logic               r_rej;
    logic               r_err_pend;
    logic               r_armed;

    logic [c_w-1:0]     w_one;
    logic [c_w-1:0]     w_cand;
    logic [c_w-1:0]     w_xq_new;
    logic [c_w-1:0]     w_prod;
    logic               w_exceeds;
    logic [EXP_W-1:0]   w_cnt_nxt;

    assign w_one     = {{(c_w-1){1'b0}}, 1'b1};
    assign w_cand    = r_r | (w_one << r_bit);
    assign w_xq_new  = {in_data_1, {FRAC_W{1'b0}}};
    assign w_cnt_nxt = r_count + EXP_W'(1);

    fx_mul_trunc #(
        .W      (c_w),
        .FRAC_W (FRAC_W)
    ) u_mul (
        .p       (r_p),
        .c       (w_cand),
        .xq      (r_xq),
        .product (w_prod),
        .exceeds (w_exceeds)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_xq        <= '0;
            r_k         <= '0;
            r_r         <= '0;
            r_p         <= '0;
            r_count     <= '0;
            r_bit       <= '0;
            r_rej       <= 1'b0;
            r_err_pend  <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_xq       <= w_xq_new;
                        r_k        <= in_data_2;
                        r_in_ready <= 1'b0;
                        r_bit      <= c_bw'(c_w - 1);
                        r_err_pend <= (in_data_2 == '0);
                        r_armed    <= 1'b0;
                        if (in_data_2 > EXP_W'(1)) begin
                            r_r     <= '0;
                            r_state <= S_LOAD;
                        end else begin
                            // k==1 is the identity; k==0 is an error with a zero result.
                            r_r     <= (in_data_2 == EXP_W'(1)) ? w_xq_new : '0;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_LOAD: begin
                    r_p     <= w_cand;
                    r_count <= EXP_W'(1);
                    r_rej   <= 1'b0;
                    r_state <= S_MUL;
                end
                S_MUL: begin
                    if (w_exceeds) begin
                        // Powers only grow from here, so the candidate is lost.
                        r_rej   <= 1'b1;
                        r_state <= S_DECIDE;
                    end else begin
                        r_p     <= w_prod;
                        r_count <= w_cnt_nxt;
                        if (w_cnt_nxt == r_k) begin
                            r_state <= S_DECIDE;
                        end
                    end
                end
                S_DECIDE: begin
                    if (!r_rej && (r_p <= r_xq)) begin
                        r_r <= w_cand;
                    end
                    if (r_bit == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_bit   <= r_bit - c_bw'(1);
                        r_state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    // One settle cycle before presenting the result gives the
                    // direct k<=1 path a fixed two-cycle latency from accept.
                    if (!r_armed) begin
                        r_armed <= 1'b1;
                    end else if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_r;
                        r_out_err   <= r_err_pend;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_data  <= '0;
                        r_out_err   <= 1'b0;
                        r_armed     <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_fx_nth_root.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fx_nth_root
// Purpose  : Self-checking bench for fx_nth_root with an arithmetic model of
//            the k-th root (largest value whose truncated power chain stays
//            within the radicand, found by binary search).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_fx_nth_root;

    localparam int IN_INT_W = 10;
    localparam int FRAC_W   = 10;
    localparam int EXP_W    = 3;
    localparam int W        = IN_INT_W + FRAC_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [IN_INT_W-1:0] in_data_1 = '0;
    logic [EXP_W-1:0]    in_data_2 = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [W-1:0]        out_data;
    logic                out_err;

    int n_vec = 0;
    int n_err = 0;
    int rdy_mode = 2;   // 0 random, 1 held low, 2 held high

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        int           k;
        time          t_acc;
    } exp_t;
    exp_t exp_q[$];

    fx_nth_root #(
        .IN_INT_W (IN_INT_W),
        .FRAC_W   (FRAC_W),
        .EXP_W    (EXP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data_1 (in_data_1),
        .in_data_2 (in_data_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit chain_ok(input longint c, input int k, input longint xq);
        longint p;
        p = c;
        for (int i = 2; i <= k; i++) begin
            p = (p * c) >> FRAC_W;
            if (p > xq) return 1'b0;
        end
        return (p <= xq);
    endfunction

    function automatic longint model_root(input int x, input int k);
        longint xq, lo, hi, mid;
        xq = longint'(x) << FRAC_W;
        if (k == 0) return 0;
        if (k == 1) return xq;
        lo = 0;
        hi = (longint'(1) << W) - 1;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (chain_ok(mid, k, xq)) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- out_ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- compare process ----------------
    logic         prev_v = 1'b0;
    logic         prev_r = 1'b0;
    logic [W-1:0] prev_d = '0;
    logic         prev_e = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        longint lat;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && prev_r)
                chk("valid_fall", {63'd0, out_valid}, 64'd0);
            if (prev_v && !prev_r) begin
                chk("valid_hold", {63'd0, out_valid}, 64'd1);
                chk("data_hold", {43'd0, out_err, out_data}, {43'd0, prev_e, prev_d});
            end
            if (!out_valid) begin
                chk("idle_zero", {43'd0, out_err, out_data}, 64'd0);
            end else begin
                chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
                if (!prev_v) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_valid", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", {44'd0, out_data}, {44'd0, e.data});
                        chk("err", {63'd0, out_err}, {63'd0, e.err});
                        lat = longint'(($time - 5 - e.t_acc) / 10);
                        if (e.k <= 1)
                            chk("latency_k01", lat, 64'd2);
                        else
                            chk("latency_bound", {63'd0, (lat <= W * (e.k + 1) + 2)}, 64'd1);
                    end
                end
            end
            prev_v = out_valid;
            prev_r = out_ready;
            prev_d = out_data;
            prev_e = out_err;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int x, input int k);
        exp_t e;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'd0, 64'd1);
        end else begin
            in_valid  = 1'b1;
            in_data_1 = IN_INT_W'(x);
            in_data_2 = EXP_W'(k);
            @(posedge clk);
            e.data  = W'(model_root(x, k));
            e.err   = (k == 0);
            e.k     = k;
            e.t_acc = $time;
            exp_q.push_back(e);
            #1;
            in_valid  = 1'b0;
            in_data_1 = IN_INT_W'($urandom);
            in_data_2 = EXP_W'($urandom);
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0 || out_valid) begin
            chk("done_timeout", 64'd0, 64'd1);
            exp_q.delete();
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {44'd0, out_data}, 64'd0);
        chk("rst_out_err", {63'd0, out_err}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    // Watchdog: the run must always end by itself.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int gd;

        // Hand-computed points that pin the model.
        chk("model_4_2",    model_root(4, 2),    64'h00800);
        chk("model_8_3",    model_root(8, 3),    64'h00800);
        chk("model_2_2",    model_root(2, 2),    64'h005A8);
        chk("model_9_2",    model_root(9, 2),    64'h00C00);
        chk("model_1023_1", model_root(1023, 1), 64'hFFC00);
        chk("model_5_0",    model_root(5, 0),    64'h0);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        rdy_mode = 2;
        send(4, 2);    wait_idle();
        send(8, 3);    wait_idle();
        send(2, 2);    wait_idle();
        send(1023, 1); wait_idle();
        send(5, 0);    wait_idle();

        // Backpressure: result held, new requests ignored.
        rdy_mode = 1;
        send(1023, 7);
        gd = 0;
        while (!out_valid && gd < 300) begin
            @(negedge clk);
            gd++;
        end
        chk("stall_valid_seen", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid  = (i % 2 == 0);
            in_data_1 = IN_INT_W'(3);
            in_data_2 = EXP_W'(1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rdy_mode = 2;
        wait_idle();

        // Reset in the middle of a computation.
        send(100, 5);
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        send(9, 2);
        wait_idle();

        // Randomized requests with random backpressure.
        rdy_mode = 0;
        repeat (25) begin
            send($urandom_range(1, 1023), $urandom_range(0, 7));
        end
        wait_idle();
        rdy_mode = 2;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fx_nth_root.md
FX_NTH_ROOT -- requirements
Module: fx_nth_root

Interface
REQ-001 SHALL have parameter IN_INT_W, default 10, integer bits of the radicand.
REQ-002 SHALL have parameter FRAC_W, default 10, fractional bits of the result and of every internal fixed-point value.
REQ-003 SHALL have parameter EXP_W, default 3, width of the exponent (root order) input.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, request strobe.
REQ-007 SHALL have port in_ready, output, 1, block can accept a request.
REQ-008 SHALL have port in_data_1, input, IN_INT_W, unsigned integer radicand X.
REQ-009 SHALL have port in_data_2, input, EXP_W, unsigned root order k.
REQ-010 SHALL have port out_valid, output, 1, result available.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port out_data, output, W=IN_INT_W+FRAC_W, unsigned Q(IN_INT_W).(FRAC_W) result.
REQ-013 SHALL have port out_err, output, 1, qualified by out_valid; set when k==0.

Function
REQ-014 SHALL accept a request on a cycle with in_valid and in_ready high, capturing X as Xq = X<<FRAC_W and k; in_ready is high only in IDLE.
REQ-015 SHALL implement states IDLE, LOAD, MUL, DECIDE, DONE; IDLE->LOAD on accept when k>=2; IDLE->DONE on accept when k<=1.
REQ-016 For k>=2, SHALL resolve result bits b = W-1 down to 0, MSB first, with candidate c = r | (1<<b) and r starting at 0.
REQ-017 LOAD SHALL set p = c and count = 1; MUL SHALL, while count < k, set p = (p*c) >> FRAC_W (truncating, full 2W-bit product, no wrap) and increment count, one multiply per cycle.
REQ-018 SHALL leave MUL for DECIDE as soon as count == k or the truncated product exceeds Xq; the latter marks the candidate rejected (early exit).
REQ-019 DECIDE SHALL set r = c if not rejected and p <= Xq, then go to LOAD for the next bit, or to DONE after b == 0; no early exit on exact equality.
REQ-020 Result SHALL be the largest W-bit r satisfying the truncated-product chain of REQ-017 being <= Xq at every step.
REQ-021 k==1 SHALL produce out_data = Xq, out_err = 0; k==0 SHALL produce out_data = 0, out_err = 1; both with out_valid exactly 2 cycles after the accept edge.
REQ-022 For k>=2, latency from accept edge to out_valid SHALL be at most W*(k+1)+2 cycles.
REQ-023 In DONE, out_valid SHALL be high and out_data/out_err stable until the cycle out_ready is high; then out_valid falls next cycle and the state returns to IDLE.
REQ-024 SHALL ignore in_valid while not in IDLE; in_data_1/in_data_2 need not be held after the accept cycle.
REQ-025 out_data and out_err SHALL be 0 whenever out_valid is low.

Reset
REQ-026 Assertion of rst_n low SHALL, immediately and asynchronously, force IDLE, in_ready high after release, out_valid 0, out_data 0, out_err 0, r, p, count and bit index 0.
REQ-027 Reset mid-computation SHALL discard the request; no out_valid SHALL follow for it.

Structure
REQ-028 A shared package SHALL hold the state enumeration, default parameter values and W derivation.
REQ-029 The truncating fixed-point multiplier with overflow compare SHALL be a sub-module fx_mul_trunc (inputs p, c, Xq; outputs product, exceeds).

Verification (defaults W=20, FRAC_W=10)
REQ-030 X=4, k=2 -> out_data 0x00800, out_err 0.
REQ-031 X=8, k=3 -> out_data 0x00800; X=2, k=2 -> out_data 0x005A8.
REQ-032 X=1023, k=1 -> out_data 0xFFC00 exactly 2 cycles after accept; X=5, k=0 -> out_data 0, out_err 1.
REQ-033 X=1023, k=7, out_ready held low 5 cycles after out_valid -> out_data stable, in_ready low, in_valid pulses ignored; latency <= 162 cycles.
REQ-034 rst_n pulsed low mid-MUL for X=100, k=5 -> outputs 0 at once, no out_valid; the following request X=9, k=2 -> out_data 0x00C00.
